// File: rtl/wb_regfile.sv
// Writeback buffer plus 32x32 register file with two combinational read ports.
// Optional macro WB_BYPASS_EN forwards the pending entry to the read ports and silences raw_hazard.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_stall,
  input  logic          wb_flush,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          raw_hazard,
  output logic          pend_valid,
  output logic [31:0]   commit_cnt
);

  logic          pv_q, pv_d;
  logic [AW-1:0] pa_q, pa_d;
  logic [DW-1:0] pd_q, pd_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          commit;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          match_rs, match_rt;

  // Flush beats stall and capture; a stalled edge freezes everything.
  always_comb begin
    pv_d   = pv_q;
    pa_d   = pa_q;
    pd_d   = pd_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (wb_flush) begin
      pv_d = 1'b0;
    end else if (!wb_stall) begin
      commit = pv_q;
      if (pv_q) cnt_d = cnt_q + 32'd1;
      if (wb_en && (wb_addr != '0)) begin
        pv_d = 1'b1;
        pa_d = wb_addr;
        pd_d = wb_data;
      end else begin
        pv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q  <= 1'b0;
      pa_q  <= '0;
      pd_q  <= '0;
      cnt_q <= '0;
    end else begin
      pv_q  <= pv_d;
      pa_q  <= pa_d;
      pd_q  <= pd_d;
      cnt_q <= cnt_d;
    end
  end

  // Register 0 never accepts a commit, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_comb begin
      regs_d[gi] = regs_q[gi];
      if ((gi != 0) && commit && (pa_q == AW'(gi))) regs_d[gi] = pd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q[gi] <= '0;
      else        regs_q[gi] <= regs_d[gi];
    end
  end

  always_comb begin
    match_rs = pv_q && (pa_q == rs_addr) && (rs_addr != '0);
    match_rt = pv_q && (pa_q == rt_addr) && (rt_addr != '0);
`ifdef WB_BYPASS_EN
    rs_data    = (rs_addr == '0) ? '0 : (match_rs ? pd_q : regs_q[rs_addr]);
    rt_data    = (rt_addr == '0) ? '0 : (match_rt ? pd_q : regs_q[rt_addr]);
    raw_hazard = 1'b0;
`else
    rs_data    = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_data    = (rt_addr == '0) ? '0 : regs_q[rt_addr];
    raw_hazard = match_rs || match_rt;
`endif
  end

  assign pend_valid = pv_q;
  assign commit_cnt = cnt_q;

endmodule
